diram_cmd_sched: RTL and testbench
==================================

// Module: diram_cmd_sched
// PURPOSE
//  Arbitrates NUM_REQ requesters onto the single DiRAM command/data port that feeds dfi.
//  Keeps an open-page table per bank and issues PRE/ACT/RD/WR while honouring tRP and tRCD.
//  Tags every read in issue order and returns read data to the issuing requester.
//  Sits between the manager's memory clients and dfi, in the clk domain.
// PARAMETERS
//  NUM_REQ     2    number of requesters
//  ID_WIDTH    1    requester index width, clog2(NUM_REQ)
//  DATA_WIDTH  320  OCP_WIDTH*PORT_NO write/read data width
//  ADDR_WIDTH  12   dfi addr width: page on ACT, zero-extended block on RD/WR
//  BLOCK_WIDTH 4    block select width
//  BANK_WIDTH  3    bank select width, 2**BANK_WIDTH banks
//  T_RP        2    clk cycles from PRE to the next ACT, same bank (>=1)
//  T_RCD       2    clk cycles from ACT to RD/WR, same bank (>=1)
//  TAG_DEPTH   8    outstanding-read tag FIFO depth (power of 2)
// PORTS
//  clk                     in   1                      clock
//  reset                   in   1                      synchronous, active-high
//  dfi__sch__init_done     in   1                      DiRAM ready
//  req_valid               in   NUM_REQ                request valid, one bit per requester
//  req_ready               out  NUM_REQ                request accepted, one-cycle pulse
//  req_write               in   NUM_REQ                1=write 0=read
//  req_bank                in   NUM_REQ*BANK_WIDTH     bank
//  req_page                in   NUM_REQ*ADDR_WIDTH     page
//  req_block               in   NUM_REQ*BLOCK_WIDTH    block within page
//  req_wrdata              in   NUM_REQ*DATA_WIDTH     write data
//  rsp_valid               out  1                      read data valid
//  rsp_id                  out  ID_WIDTH               requester owning rsp_rddata
//  rsp_rddata              out  DATA_WIDTH             read data
//  sch__dfi__cs            out  1                      command valid
//  sch__dfi__cmd1/cmd0     out  1/1                    {cmd1,cmd0}: 00 ACT, 01 RD, 10 WR, 11 PRE
//  sch__dfi__addr          out  ADDR_WIDTH             page or block
//  sch__dfi__bank          out  BANK_WIDTH             bank
//  sch__dfi__wrdata        out  DATA_WIDTH             write data, valid in WR cycle only
//  dfi__sch__rddata_valid  in   1                      read data valid from dfi
//  dfi__sch__rddata        in   DATA_WIDTH             read data from dfi
//  err_unexp_rd            out  1                      sticky: read data received with no tag
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=INIT; all banks closed; tag FIFO empty; RR pointer=0; err cleared.
//  - All sch__dfi__* outputs are registered. cs=0 means cmd=00, addr/bank/wrdata=0.
//  - At most one command per cycle.
//  - FSM states: INIT, IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, ACCESS.
//    - INIT: leaves to IDLE when init_done=1. init_done is ignored outside INIT.
//    - IDLE: round-robin grant over req_valid, starting at the RR pointer. Latches the
//      granted request. Next state: ACCESS if the bank is open on the same page, ACT if
//      the bank is closed, PRE if the bank is open on another page.
//    - PRE: drives cmd 11 for one cycle, marks the bank closed, then WAIT_RP for T_RP-1
//      cycles, then ACT.
//    - ACT: drives cmd 00 with addr=page, records page open, then WAIT_RCD for T_RCD-1
//      cycles, then ACCESS.
//    - ACCESS: drives RD(01)/WR(10) with addr={0,block}, bank. WR also drives wrdata.
//      Same cycle: req_ready[granted]=1, RR pointer = granted+1 (mod NUM_REQ). Next IDLE.
//  - Latency (request valid in IDLE cycle 0):
//    - page hit: RD/WR at cycle 1
//    - bank closed: ACT at 1, RD/WR at 1+T_RCD
//    - page conflict: PRE at 1, ACT at 1+T_RP, RD/WR at 1+T_RP+T_RCD
//  - Open-page policy: pages stay open until a conflict. No refresh.
//  - Reads:
//    - Each RD pushes the granted id into the tag FIFO.
//    - A RD in ACCESS stalls (cs=0, no ready) while the FIFO is full; WR never stalls.
//    - Push and pop in the same cycle leaves the count unchanged. The full check uses the
//      registered count.
//  - Response: for each dfi__sch__rddata_valid cycle, pop the tag FIFO. Next cycle
//    rsp_valid=1, rsp_id=tag, rsp_rddata=dfi data. Responses come back in issue order.
//  - rddata_valid with an empty FIFO: data is dropped, rsp_valid stays 0, err_unexp_rd=1
//    until reset.
//  - req_* fields must be stable while req_valid=1 and ready=0. They are latched at grant;
//    later changes are ignored.
//  - Reset mid-operation: any in-progress command sequence is abandoned and the next
//    cycle outputs are idle.
// TESTING
//  - init_done=0 for 10 cycles with req_valid=01: cs stays 0. Then init_done=1 -> ACT
//    bank0 page5 at grant+1, RD at grant+1+T_RCD, req_ready[0] pulses with the RD.
//  - Second read to bank0 page5 -> RD at cycle 1 (hit), no ACT/PRE.
//  - Read bank0 page9 after page5 open -> PRE@1, ACT(addr=9)@1+T_RP, RD@1+T_RP+T_RCD.
//  - Both requesters valid continuously, hit traffic -> grants alternate 0,1,0,1;
//    WR cycles carry the matching req_wrdata.
//  - 9 reads with no rddata_valid (TAG_DEPTH=8) -> 9th RD stalls. Return one data word
//    -> rsp_id of the first read; 9th RD issues next cycle.
//  - rddata_valid with an empty FIFO -> err_unexp_rd=1, rsp_valid=0.
//    Reset asserted mid-PRE -> outputs 0 next cycle.

Source files
------------

// File: rtl/diram_cmd_sched.sv
// DiRAM command scheduler: round-robin requester arbitration, open-page
// bank tracking with tRP/tRCD spacing, and in-order read tag return.
module diram_cmd_sched #(
  parameter int NUM_REQ     = 2,
  parameter int ID_WIDTH    = 1,
  parameter int DATA_WIDTH  = 320,
  parameter int ADDR_WIDTH  = 12,
  parameter int BLOCK_WIDTH = 4,
  parameter int BANK_WIDTH  = 3,
  parameter int T_RP        = 2,
  parameter int T_RCD       = 2,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dfi__sch__init_done,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*BANK_WIDTH-1:0]     req_bank,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_page,
  input  logic [NUM_REQ*BLOCK_WIDTH-1:0]    req_block,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wrdata,
  output logic                              rsp_valid,
  output logic [ID_WIDTH-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]             rsp_rddata,
  output logic                              sch__dfi__cs,
  output logic                              sch__dfi__cmd1,
  output logic                              sch__dfi__cmd0,
  output logic [ADDR_WIDTH-1:0]             sch__dfi__addr,
  output logic [BANK_WIDTH-1:0]             sch__dfi__bank,
  output logic [DATA_WIDTH-1:0]             sch__dfi__wrdata,
  input  logic                              dfi__sch__rddata_valid,
  input  logic [DATA_WIDTH-1:0]             dfi__sch__rddata,
  output logic                              err_unexp_rd
);

  localparam int NBANK  = 2**BANK_WIDTH;
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMAX   = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int WCNT_W = $clog2(TMAX + 1);

  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_PRE = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [ID_WIDTH-1:0]     rr_q, rr_d;
  logic [ID_WIDTH-1:0]     gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [BANK_WIDTH-1:0]   bnk_q, bnk_d;
  logic [ADDR_WIDTH-1:0]   pg_q, pg_d;
  logic [BLOCK_WIDTH-1:0]  blk_q, blk_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic [NBANK-1:0]        open_q, open_d;
  logic [ADDR_WIDTH-1:0]   page_q [NBANK];
  logic [ADDR_WIDTH-1:0]   page_d [NBANK];

  logic                    cs_q, cs_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BANK_WIDTH-1:0]   obank_q, obank_d;
  logic [DATA_WIDTH-1:0]   owd_q, owd_d;
  logic [NUM_REQ-1:0]      rdy_q, rdy_d;

  logic [ID_WIDTH-1:0]     tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rv_q, rv_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                    err_q, err_d;

  logic                    issue;
  logic                    push;
  logic                    pop;

  always_comb begin
    int  pick;
    int  idx;
    logic found;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    bnk_d   = bnk_q;
    pg_d    = pg_q;
    blk_d   = blk_q;
    wd_d    = wd_q;
    open_d  = open_q;
    page_d  = page_q;
    cs_d    = 1'b0;
    cmd_d   = C_ACT;
    addr_d  = '0;
    obank_d = '0;
    owd_d   = '0;
    rdy_d   = '0;
    pick    = 0;
    idx     = 0;
    found   = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state_q)
      S_INIT: begin
        if (dfi__sch__init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (found) begin
          gnt_d = ID_WIDTH'(pick);
          wr_d  = req_write[pick];
          bnk_d = req_bank[pick*BANK_WIDTH +: BANK_WIDTH];
          pg_d  = req_page[pick*ADDR_WIDTH +: ADDR_WIDTH];
          blk_d = req_block[pick*BLOCK_WIDTH +: BLOCK_WIDTH];
          wd_d  = req_wrdata[pick*DATA_WIDTH +: DATA_WIDTH];
          if (!open_q[bnk_d])            state_d = S_ACT;
          else if (page_q[bnk_d] == pg_d) state_d = S_ACCESS;
          else                            state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_WAIT_RP;
          wcnt_d  = WCNT_W'(T_RP - 2);
        end else begin
          state_d = S_ACT;
        end
      end
      S_WAIT_RP: begin
        if (wcnt_q == '0) state_d = S_ACT;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_WAIT_RCD;
          wcnt_d  = WCNT_W'(T_RCD - 2);
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_WAIT_RCD: begin
        if (wcnt_q == '0) state_d = S_ACCESS;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_ACCESS: begin
        state_d = cs_q ? S_IDLE : S_ACCESS;
      end
      default: state_d = S_INIT;
    endcase

    // Commands are registered on entry so they appear in the state's own cycle
    if (state_d == S_PRE) begin
      cs_d          = 1'b1;
      cmd_d         = C_PRE;
      obank_d       = bnk_d;
      open_d[bnk_d] = 1'b0;
    end
    if (state_d == S_ACT) begin
      cs_d          = 1'b1;
      cmd_d         = C_ACT;
      addr_d        = pg_d;
      obank_d       = bnk_d;
      open_d[bnk_d] = 1'b1;
      page_d[bnk_d] = pg_d;
    end

    issue = (state_d == S_ACCESS) &&
            (wr_d || cnt_q != CNT_W'(TAG_DEPTH));
    if (issue) begin
      cs_d         = 1'b1;
      cmd_d        = wr_d ? C_WR : C_RD;
      addr_d       = ADDR_WIDTH'(blk_d);
      obank_d      = bnk_d;
      owd_d        = wr_d ? wd_d : '0;
      rdy_d[gnt_d] = 1'b1;
      rr_d         = ID_WIDTH'((int'(gnt_d) + 1) % NUM_REQ);
    end

    push   = issue && !wr_d;
    pop    = dfi__sch__rddata_valid && (cnt_q != '0);
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rv_d   = pop;
    rid_d  = pop ? tag_mem[rptr_q] : '0;
    rdat_d = pop ? dfi__sch__rddata : '0;
    err_d  = err_q | (dfi__sch__rddata_valid && cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      wcnt_q  <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      bnk_q   <= '0;
      pg_q    <= '0;
      blk_q   <= '0;
      wd_q    <= '0;
      open_q  <= '0;
      for (int i = 0; i < NBANK; i++) page_q[i] <= '0;
      cs_q    <= 1'b0;
      cmd_q   <= C_ACT;
      addr_q  <= '0;
      obank_q <= '0;
      owd_q   <= '0;
      rdy_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      bnk_q   <= bnk_d;
      pg_q    <= pg_d;
      blk_q   <= blk_d;
      wd_q    <= wd_d;
      open_q  <= open_d;
      page_q  <= page_d;
      cs_q    <= cs_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      obank_q <= obank_d;
      owd_q   <= owd_d;
      rdy_q   <= rdy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr_q] <= gnt_d;
  end

  assign req_ready        = rdy_q;
  assign rsp_valid        = rv_q;
  assign rsp_id           = rid_q;
  assign rsp_rddata       = rdat_q;
  assign sch__dfi__cs     = cs_q;
  assign sch__dfi__cmd1   = cmd_q[1];
  assign sch__dfi__cmd0   = cmd_q[0];
  assign sch__dfi__addr   = addr_q;
  assign sch__dfi__bank   = obank_q;
  assign sch__dfi__wrdata = owd_q;
  assign err_unexp_rd     = err_q;

endmodule

// File: tb/tb_diram_cmd_sched.sv
// Scoreboard bench for diram_cmd_sched: directed requests push expected
// dfi commands and responses; a negedge monitor pops and compares.
module tb_diram_cmd_sched;
  localparam int NR = 2, IW = 1, DW = 320, AW = 12, KW = 4, BW = 3;
  localparam int TRP = 2, TRCD = 2, TD = 8;

  logic              clk, reset, init_done;
  logic [NR-1:0]     req_valid, req_ready, req_write;
  logic [NR*BW-1:0]  req_bank;
  logic [NR*AW-1:0]  req_page;
  logic [NR*KW-1:0]  req_block;
  logic [NR*DW-1:0]  req_wrdata;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_rddata;
  logic              cs, cmd1, cmd0;
  logic [AW-1:0]     addr;
  logic [BW-1:0]     bank;
  logic [DW-1:0]     wrdata;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              err;

  diram_cmd_sched #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BLOCK_WIDTH(KW), .BANK_WIDTH(BW), .T_RP(TRP), .T_RCD(TRCD),
    .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .dfi__sch__init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_page(req_page), .req_block(req_block),
    .req_wrdata(req_wrdata), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rddata(rsp_rddata), .sch__dfi__cs(cs), .sch__dfi__cmd1(cmd1),
    .sch__dfi__cmd0(cmd0), .sch__dfi__addr(addr), .sch__dfi__bank(bank),
    .sch__dfi__wrdata(wrdata), .dfi__sch__rddata_valid(rd_valid),
    .dfi__sch__rddata(rd_data), .err_unexp_rd(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [BW-1:0] bank;
    logic [DW-1:0] wd;
    int            id;
    int            lo;
    int            hi;
  } cmd_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   ord[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  cmd_t          me;
  rsp_t          mr;
  logic [NR-1:0] exp_rdy;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (cs) begin
        n_chk++;
        if (exp_cmd.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_unexp: got cmd=%b%b bank=%0d addr=%0h cyc=%0d, required no command",
                   cmd1, cmd0, bank, addr, cyc);
        end else begin
          me = exp_cmd.pop_front();
          exp_rdy = (me.id >= 0) ? (NR'(1) << me.id) : '0;
          if ({cmd1, cmd0} !== me.cmd || addr !== me.addr || bank !== me.bank ||
              wrdata !== me.wd || req_ready !== exp_rdy ||
              cyc < me.lo || cyc > me.hi) begin
            n_fail++;
            $display("FAIL cmd: got cmd=%b%b addr=%0h bank=%0d rdy=%b cyc=%0d wd=%0h, required cmd=%b addr=%0h bank=%0d rdy=%b cyc=%0d..%0d wd=%0h",
                     cmd1, cmd0, addr, bank, req_ready, cyc, wrdata,
                     me.cmd, me.addr, me.bank, exp_rdy, me.lo, me.hi, me.wd);
          end
        end
      end else if (req_ready != '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ready_nocmd: got ready=%b at cyc=%0d, required 0", req_ready, cyc);
      end
      if (rsp_valid) begin
        n_chk++;
        if (exp_rsp.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexp: got id=%0d at cyc=%0d, required no response", rsp_id, cyc);
        end else begin
          mr = exp_rsp.pop_front();
          if (int'(rsp_id) != mr.id || rsp_rddata !== mr.d) begin
            n_fail++;
            $display("FAIL rsp: got id=%0d data=%0h, required id=%0d data=%0h",
                     rsp_id, rsp_rddata, mr.id, mr.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  function automatic logic [DW-1:0] mkd(input int k);
    return {10{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic push_cmd(input logic [1:0] c, input int a, input int b,
                          input logic [DW-1:0] d, input int id,
                          input int lo, input int hi);
    cmd_t e;
    e.cmd = c; e.addr = AW'(a); e.bank = BW'(b); e.wd = d;
    e.id = id; e.lo = lo; e.hi = hi;
    exp_cmd.push_back(e);
  endtask

  // kind: 0 page hit, 1 bank closed, 2 page conflict; g = IDLE grant cycle
  task automatic req(input int id, input bit wr, input int bk, input int pg,
                     input int blk, input logic [DW-1:0] d, input int kind,
                     input int g, input int dly, input int slack);
    int a;
    req_write[id] = wr;
    req_bank[id*BW +: BW] = BW'(bk);
    req_page[id*AW +: AW] = AW'(pg);
    req_block[id*KW +: KW] = KW'(blk);
    req_wrdata[id*DW +: DW] = d;
    req_valid[id] = 1'b1;
    a = g + 1;
    if (kind == 2) begin
      push_cmd(2'b11, 0, bk, '0, -1, a, a);
      a += TRP;
    end
    if (kind >= 1) begin
      push_cmd(2'b00, pg, bk, '0, -1, a, a);
      a += TRCD;
    end
    push_cmd(wr ? 2'b10 : 2'b01, blk, bk, wr ? d : '0, id, a + dly, a + dly + slack);
    if (!wr) ord.push_back(id);
  endtask

  task automatic wait_pulse(input int id);
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (req_ready[id]) got = 1;
      else @(negedge clk);
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: got no ready[%0d] in 60 cycles, required a pulse", id);
    end
  endtask

  task automatic wait_ready(input int id);
    wait_pulse(id);
    req_valid[id] = 1'b0;
    @(negedge clk);
  endtask

  task automatic ret_data(input logic [DW-1:0] d);
    rsp_t r;
    r.id = (ord.size() > 0) ? ord.pop_front() : -1;
    r.d = d;
    exp_rsp.push_back(r);
    rd_valid = 1'b1;
    rd_data = d;
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data = '0;
  endtask

  int c, c9;
  bit seen;

  initial begin
    reset = 1'b1; init_done = 1'b0;
    req_valid = '0; req_write = '0; req_bank = '0; req_page = '0;
    req_block = '0; req_wrdata = '0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(cs), 0);
    chk("rst_cmd", 64'({cmd1, cmd0}), 0);
    chk("rst_addr_bank", 64'({addr, bank}), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_rsp", 64'(rsp_valid), 0);
    chk("rst_err", 64'(err), 0);
    reset = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // init hold, then closed-bank read bank0 page5
    c = cyc;
    req(0, 0, 0, 5, 3, '0, 1, c + 11, 0, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cs) seen = 1;
    end
    chk("init_hold_cs", 64'(seen), 0);
    init_done = 1'b1;
    wait_ready(0);

    req(0, 0, 0, 5, 7, '0, 0, cyc, 0, 0);
    wait_ready(0);

    req(1, 0, 0, 9, 1, '0, 2, cyc, 0, 0);
    wait_ready(1);

    ret_data(mkd(1));
    ret_data(mkd(2));
    ret_data(mkd(3));
    repeat (2) @(negedge clk);

    // both requesters writing continuously
    c = cyc;
    req(0, 1, 0, 9, 2, mkd(10), 0, c, 0, 0);
    req(1, 1, 0, 9, 4, mkd(11), 0, c, 2, 0);
    push_cmd(2'b10, 2, 0, mkd(10), 0, c + 5, c + 5);
    push_cmd(2'b10, 4, 0, mkd(11), 1, c + 7, c + 7);
    wait_pulse(0); @(negedge clk);
    wait_pulse(1); @(negedge clk);
    wait_pulse(0); @(negedge clk);
    wait_pulse(1);
    req_valid = '0;
    @(negedge clk);

    // fill the tag FIFO, 9th read stalls until one word returns
    for (int k = 0; k < 8; k++) begin
      req(k % 2, 0, 0, 9, k, '0, 0, cyc, 0, 0);
      wait_ready(k % 2);
    end
    c9 = cyc;
    req(0, 0, 0, 9, 8, '0, 0, c9, 5, 1);
    while (cyc < c9 + 5) @(negedge clk);
    ret_data(mkd(20));
    wait_ready(0);
    for (int k = 0; k < 8; k++) ret_data(mkd(21 + k));
    repeat (3) @(negedge clk);
    chk("cmd_q_empty", 64'(exp_cmd.size()), 0);
    chk("rsp_q_empty", 64'(exp_rsp.size()), 0);
    chk("err_before", 64'(err), 0);

    // unexpected read data
    rd_valid = 1'b1;
    rd_data = mkd(99);
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data = '0;
    @(negedge clk);
    chk("err_unexp", 64'(err), 1);
    chk("rsp_unexp_none", 64'(rsp_valid), 0);
    @(negedge clk);
    chk("err_sticky", 64'(err), 1);

    // reset during PRE
    req(0, 0, 0, 2, 0, '0, 2, cyc, 0, 0);
    @(negedge clk);
    chk("pre_cs", 64'(cs), 1);
    chk("pre_cmd", 64'({cmd1, cmd0}), 3);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_rst_cs", 64'(cs), 0);
    chk("mid_rst_cmd", 64'({cmd1, cmd0, addr, bank}), 0);
    chk("mid_rst_ready", 64'(req_ready), 0);
    chk("mid_rst_err", 64'(err), 0);
    exp_cmd.delete();
    ord.delete();
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
